// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: self-test sequencer for an N_IN-input, 1-output combinational gate.
// On start, every input vector 0..2^N_IN-1 is driven in ascending order. Each vector
// is held SETTLE cycles, then the gate output is sampled in one more cycle and compared
// with EXP_TT. The block reports pass, the mismatch count and the lowest failing vector.
//
// Optional feature: define GATE_SWEEP_OBS_EN to add the obs_tt port, which holds the
// observed truth table of the last sweep.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          sweep request, sampled only in IDLE
//   dut_in         vector driven to the gate (0 outside a sweep)
//   dut_out        gate output
//   busy           high from the first DRIVE cycle through the last SAMPLE cycle
//   done           one-cycle pulse when a sweep completes
//   pass           last sweep had zero mismatches (valid from done until next start)
//   err_cnt        mismatch count of the last sweep
//   first_fail_vec lowest failing vector, 0 when err_cnt == 0
//   obs_tt         observed truth table (GATE_SWEEP_OBS_EN only)
module gate_sweep_ctrl #(
  parameter int unsigned        N_IN   = 2,
  parameter int unsigned        SETTLE = 1,
  parameter logic [2**N_IN-1:0] EXP_TT = 4'b1001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic [N_IN-1:0]   first_fail_vec
`ifdef GATE_SWEEP_OBS_EN
  ,
  output logic [2**N_IN-1:0] obs_tt
`endif
);

  localparam int unsigned     ERR_W    = N_IN + 1;
  localparam int unsigned     CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [N_IN-1:0]    din_q, din_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [N_IN-1:0]    ffv_q, ffv_d;
  logic               mismatch;
`ifdef GATE_SWEEP_OBS_EN
  logic [2**N_IN-1:0] obs_q, obs_d;
`endif

  assign mismatch = (dut_out != EXP_TT[vec_q]);

  // Next-state and next-output logic; registered outputs are derived from the
  // next state so they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
`ifdef GATE_SWEEP_OBS_EN
    obs_d   = obs_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          cnt_d   = '0;
          vec_d   = '0;
          pass_d  = 1'b0;
          err_d   = '0;
          ffv_d   = '0;
`ifdef GATE_SWEEP_OBS_EN
          obs_d   = '0;
`endif
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
`ifdef GATE_SWEEP_OBS_EN
        obs_d[vec_q] = dut_out;
`endif
        if (mismatch) begin
          err_d = err_q + ERR_W'(1);
          if (err_q == '0) begin
            ffv_d = vec_q;
          end
        end
        // The index stops at the last vector; it is reloaded on the next start.
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d = DRIVE;
          vec_d   = vec_q + N_IN'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    din_d  = busy_d ? vec_d : '0;
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
`ifdef GATE_SWEEP_OBS_EN
      obs_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
`ifdef GATE_SWEEP_OBS_EN
      obs_q   <= obs_d;
`endif
    end
  end

  assign dut_in         = din_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail_vec = ffv_q;
`ifdef GATE_SWEEP_OBS_EN
  assign obs_tt         = obs_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) each
// drive a modelled XNOR gate whose output can be flipped per vector by a fault mask.
module tb_gate_sweep_ctrl;

  localparam logic [3:0] XNOR_TT = 4'b1001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mask_a = 4'h0;
  logic [3:0] mask_b = 4'h0;

  logic [1:0] din_a, din_b, ffv_a, ffv_b;
  logic       dout_a, dout_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [2:0] err_a, err_b;
  logic [3:0] obs_a, obs_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Gate under test: XNOR, with the output inverted for every vector set in the mask.
  assign dout_a = ~(din_a[1] ^ din_a[0]) ^ mask_a[din_a];
  assign dout_b = ~(din_b[1] ^ din_b[0]) ^ mask_b[din_b];

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXP_TT(XNOR_TT)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(din_a), .dut_out(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_fail_vec(ffv_a)
`ifdef GATE_SWEEP_OBS_EN
    , .obs_tt(obs_a)
`endif
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(3), .EXP_TT(XNOR_TT)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(din_b), .dut_out(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_fail_vec(ffv_b)
`ifdef GATE_SWEEP_OBS_EN
    , .obs_tt(obs_b)
`endif
  );

`ifndef GATE_SWEEP_OBS_EN
  assign obs_a = 4'h0;
  assign obs_b = 4'h0;
`endif

  // Behavioural model: k counts cycles since the start edge (0 = idle,
  // 1..4*(s+1) = busy, 4*(s+1)+1 = done cycle).
  typedef struct packed {
    int         k;
    int         err;
    int         ffv;
    logic       pass;
    logic [3:0] obs;
  } mstate_t;

  function automatic mstate_t mstep(input mstate_t m, input logic st, input int s,
                                    input logic [3:0] mask);
    mstate_t    r = m;
    int         b = 4 * (s + 1);
    logic [1:0] v;
    logic       g;
    if (m.k == 0) begin
      if (st) begin
        r   = '0;
        r.k = 1;
      end
    end else if (m.k <= b) begin
      if (m.k % (s + 1) == 0) begin
        v = 2'((m.k - 1) / (s + 1));
        g = ~(v[1] ^ v[0]) ^ mask[v];
        r.obs[v] = g;
        if (g != XNOR_TT[v]) begin
          if (r.err == 0) r.ffv = int'(v);
          r.err = r.err + 1;
        end
      end
      r.k = m.k + 1;
      if (r.k == b + 1) r.pass = (r.err == 0);
    end else begin
      r.k = 0;
    end
    return r;
  endfunction

  function automatic int e_busy(input mstate_t m, input int s);
    return (m.k >= 1 && m.k <= 4 * (s + 1)) ? 1 : 0;
  endfunction

  function automatic int e_din(input mstate_t m, input int s);
    return (e_busy(m, s) == 1) ? (m.k - 1) / (s + 1) : 0;
  endfunction

  function automatic int e_done(input mstate_t m, input int s);
    return (m.k == 4 * (s + 1) + 1) ? 1 : 0;
  endfunction

  mstate_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(ma, start, 1, mask_a);
      mb <= mstep(mb, start, 3, mask_b);
    end
  end

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("a_busy", int'(busy_a), e_busy(ma, 1));
      check("a_din",  int'(din_a),  e_din(ma, 1));
      check("a_done", int'(done_a), e_done(ma, 1));
      check("a_pass", int'(pass_a), int'(ma.pass));
      check("a_err",  int'(err_a),  ma.err);
      check("a_ffv",  int'(ffv_a),  ma.ffv);
      check("b_busy", int'(busy_b), e_busy(mb, 3));
      check("b_din",  int'(din_b),  e_din(mb, 3));
      check("b_done", int'(done_b), e_done(mb, 3));
      check("b_pass", int'(pass_b), int'(mb.pass));
      check("b_err",  int'(err_b),  mb.err);
      check("b_ffv",  int'(ffv_b),  mb.ffv);
`ifdef GATE_SWEEP_OBS_EN
      check("a_obs",  int'(obs_a),  int'(ma.obs));
      check("b_obs",  int'(obs_b),  int'(mb.obs));
`endif
    end
  end

  int a_err, a_pass, a_ffv, a_obs, b_err, b_pass;

  // Pulse start, optionally re-pulse it at cycle repulse_at, and record the cycle
  // (counted from the start edge) at which each instance raises done.
  task automatic sweep(input int repulse_at, output int ca, output int cb);
    ca = 0;
    cb = 0;
    start = 1'b1;
    for (int c = 1; c <= 40 && (ca == 0 || cb == 0); c++) begin
      @(negedge clk);
      start = (c == repulse_at);
      if (done_a && ca == 0) begin
        ca = c; a_err = int'(err_a); a_pass = int'(pass_a);
        a_ffv = int'(ffv_a); a_obs = int'(obs_a);
      end
      if (done_b && cb == 0) begin
        cb = c; b_err = int'(err_b); b_pass = int'(pass_b);
      end
    end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((ma.k != 0 || mb.k != 0) && c < 80) begin
      @(negedge clk);
      c++;
    end
    if (c >= 80) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles, want idle", c);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca, cb, n;

    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy_a), 0);
    check("rst_din",  int'(din_a),  0);
    check("rst_err",  int'(err_b),  0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ideal XNOR.
    mask_a = 4'h0; mask_b = 4'h0;
    sweep(0, ca, cb);
    check("t1_done_cycle_a", ca, 9);
    check("t1_done_cycle_b", cb, 17);
    check("t1_err",  a_err, 0);
    check("t1_pass", a_pass, 1);
    check("t1_ffv",  a_ffv, 0);
    check("t1_pass_b", b_pass, 1);
    wait_idle();

    // XOR in place of XNOR.
    mask_a = 4'hF; mask_b = 4'hF;
    sweep(0, ca, cb);
    check("t2_err",  a_err, 4);
    check("t2_pass", a_pass, 0);
    check("t2_ffv",  a_ffv, 0);
    check("t2_err_b", b_err, 4);
`ifdef GATE_SWEEP_OBS_EN
    check("t2_obs", a_obs, 6);
`endif
    wait_idle();

    // Output inverted only for vector 2.
    mask_a = 4'b0100; mask_b = 4'b0100;
    sweep(0, ca, cb);
    check("t3_err",  a_err, 1);
    check("t3_ffv",  a_ffv, 2);
    check("t3_pass", a_pass, 0);
`ifdef GATE_SWEEP_OBS_EN
    check("t3_obs", a_obs, 13);
`endif
    wait_idle();

    // start re-pulsed while busy.
    mask_a = 4'h0; mask_b = 4'h0;
    sweep(3, ca, cb);
    check("t4_done_cycle_a", ca, 9);
    check("t4_done_cycle_b", cb, 17);
    wait_idle();

    // start held high: restart one cycle after done, results cleared.
    mask_a = 4'b0100;
    start = 1'b1;
    n = 0;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4h_done_cycle", n, 9);
    check("t4h_err_at_done", int'(err_a), 1);
    @(negedge clk);
    check("t4h_idle_gap", int'(busy_a), 0);
    @(negedge clk);
    check("t4h_restart", int'(busy_a), 1);
    check("t4h_err_clr", int'(err_a), 0);
    check("t4h_ffv_clr", int'(ffv_a), 0);
    start = 1'b0;
    wait_idle();

    // Reset during DRIVE of vector 2.
    mask_a = 4'h0; mask_b = 4'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_pre_din", int'(din_a), 2);
    check("t5_pre_busy", int'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy_a", int'(busy_a), 0);
    check("t5_din_a",  int'(din_a),  0);
    check("t5_busy_b", int'(busy_b), 0);
    check("t5_din_b",  int'(din_b),  0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_stay_idle", int'(busy_a), 0);

    // Randomized sweeps with random fault masks, stray starts and occasional resets.
    for (int it = 0; it < 30; it++) begin
      wait_idle();
      mask_a = 4'($urandom);
      mask_b = 4'($urandom);
      if ($urandom_range(0, 2) == 0) mask_a = 4'h0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = int'($urandom_range(0, 25));
      for (int j = 0; j < n; j++) begin
        @(negedge clk);
        start = ($urandom_range(0, 5) == 0);
      end
      start = 1'b0;
      if (it % 10 == 9) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
